// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack ALU with valid/ready handshake and carry/overflow flags
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy,
   output logic             ov
);
   logic             r_s1_v, r_f, r_no;
   logic [WIDTH-1:0] r_x, r_y;
   logic             r_s2_v, r_zr, r_ng, r_cy, r_ov;
   logic [WIDTH-1:0] r_out;
   logic             w_s1_adv, w_s2_adv;
   logic [WIDTH-1:0] w_xz, w_yz, w_xp, w_yp, w_r, w_out;
   logic [WIDTH:0]   w_sum;

   // Handshake advance, operand preconditioning and the S1 -> S2 result path
   always_comb begin
      w_s2_adv = !r_s2_v || out_ready;
      w_s1_adv = !r_s1_v || w_s2_adv;
      w_xz     = zx ? '0 : x;
      w_yz     = zy ? '0 : y;
      w_xp     = nx ? ~w_xz : w_xz;
      w_yp     = ny ? ~w_yz : w_yz;
      w_sum    = {1'b0, r_x} + {1'b0, r_y};
      w_r      = r_f ? w_sum[WIDTH-1:0] : (r_x & r_y);
      w_out    = r_no ? ~w_r : w_r;
   end

   // Stage 1: capture preconditioned operands whenever the stage can advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
         r_f    <= 1'b0;
         r_no   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_v <= in_valid;
         r_x    <= w_xp;
         r_y    <= w_yp;
         r_f    <= f;
         r_no   <= no;
      end
   end

   // Stage 2: compute result and flags; holds stable while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v <= 1'b0;
         r_out  <= '0;
         r_zr   <= 1'b0;
         r_ng   <= 1'b0;
         r_cy   <= 1'b0;
         r_ov   <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_v <= r_s1_v;
         r_out  <= w_out;
         r_zr   <= w_out == '0;
         r_ng   <= w_out[WIDTH-1];
         r_cy   <= r_f & w_sum[WIDTH];
         r_ov   <= r_f & (r_x[WIDTH-1] == r_y[WIDTH-1]) & (w_sum[WIDTH-1] != r_x[WIDTH-1]);
      end
   end

   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_v;
   assign out       = r_out;
   assign zr        = r_zr;
   assign ng        = r_ng;
   assign cy        = r_cy;
   assign ov        = r_ov;
endmodule
